// File: rtl/audio_pwm_sink_pkg.sv
// Shared audio definitions: sample width, PWM midscale and offset-binary conversion.
package audio_pwm_sink_pkg;

  localparam int SAMPLE_W = 21;

  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic logic [31:0] midscale(input int bits);
    midscale = 32'd1 << (bits - 1);
  endfunction

  // Signed two's complement to offset binary: flip the sign bit.
  function automatic sample_t to_offset_binary(input sample_t s);
    to_offset_binary = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/audio_pwm_sink_fifo.sv
// Synchronous first-word-fall-through sample FIFO with occupancy count.
module sample_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // sample storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      else           wr_ptr_r <= wr_ptr_r;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      else           rd_ptr_r <= rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/audio_pwm_sink.sv
// Audio PWM sink: FIFO-buffered signed samples drive a 2^PWM_BITS-cycle PWM output.
// Optional first-order dither of the truncated bits: define AUDIO_PWM_SINK_DITHER_EN.
module audio_pwm_sink
  import audio_pwm_sink_pkg::*;
#(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int PWM_BITS       = 10,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [SAMPLE_W-1:0]           sample,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int LOW_W = SAMPLE_W - PWM_BITS;
  localparam int unused_cpu_clock_freq = CPU_CLOCK_FREQ;
  localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   DUTY_MID = (PWM_BITS+1)'(midscale(PWM_BITS));

  logic [PWM_BITS-1:0] cnt_r;
  logic [PWM_BITS:0]   duty_r;
  logic [PWM_BITS:0]   duty_next_s;
  logic [SAMPLE_W-1:0] fifo_dout_s;
  logic [SAMPLE_W-1:0] offset_s;
  logic [CW-1:0]       fifo_count_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                push_s;
  logic                pop_attempt_s;
  logic                pop_s;
  logic                carry_s;

  assign sample_ready  = ~fifo_full_s & ~rst;
  assign push_s        = sample_valid & sample_ready;
  assign pop_attempt_s = enable & (cnt_r == CNT_MAX);
  assign pop_s         = pop_attempt_s & ~fifo_empty_s;
  assign offset_s      = to_offset_binary(fifo_dout_s);
  assign fifo_count    = fifo_count_s;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (sample),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

`ifdef AUDIO_PWM_SINK_DITHER_EN
  logic [LOW_W-1:0] acc_r;
  logic [LOW_W:0]   acc_sum_s;

  assign acc_sum_s = {1'b0, acc_r} + {1'b0, offset_s[LOW_W-1:0]};
  assign carry_s   = acc_sum_s[LOW_W];

  // residue accumulator, advanced only by samples actually consumed
  always_ff @(posedge clk) begin
    if (rst)        acc_r <= {LOW_W{1'b0}};
    else if (pop_s) acc_r <= acc_sum_s[LOW_W-1:0];
    else            acc_r <= acc_r;
  end
`else
  logic unused_low_s;

  assign carry_s      = 1'b0;
  assign unused_low_s = ^offset_s[LOW_W-1:0];
`endif

  // duty for the coming period: FIFO head, or midscale when starved
  always_comb begin
    duty_next_s = DUTY_MID;
    if (pop_s) begin
      duty_next_s = {1'b0, offset_s[SAMPLE_W-1 -: PWM_BITS]} + {{PWM_BITS{1'b0}}, carry_s};
    end else begin
      duty_next_s = DUTY_MID;
    end
  end

  // period counter, duty latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {PWM_BITS{1'b0}};
      duty_r    <= DUTY_MID;
      pwm_out   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (enable)        cnt_r  <= cnt_r + PWM_BITS'(1);
      else               cnt_r  <= {PWM_BITS{1'b0}};
      if (pop_attempt_s) duty_r <= duty_next_s;
      else               duty_r <= duty_r;
      pwm_out   <= enable & ({1'b0, cnt_r} < duty_r);
      underflow <= pop_attempt_s & fifo_empty_s;
    end
  end

endmodule

// File: tb/tb_audio_pwm_sink.sv
// Directed bench for audio_pwm_sink with PWM_BITS=8, FIFO_DEPTH=4.
module tb_audio_pwm_sink;

  localparam int PWM_BITS   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PERIOD     = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [20:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        pwm_out;
  logic        underflow;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_pwm_sink #(
    .CPU_CLOCK_FREQ (50_000_000),
    .PWM_BITS       (PWM_BITS),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .underflow    (underflow),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [20:0] v);
    sample       = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  // One full PWM period; starts aligned with cnt=0 after enable or a previous period.
  task automatic run_period(input string tag, input int exp_high, input int exp_ufl);
    int h;
    int u;
    h = 0;
    u = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (pwm_out === 1'b1)   h++;
      if (underflow === 1'b1) u++;
    end
    check({tag, "_high"}, h, exp_high);
    check({tag, "_ufl"}, u, exp_ufl);
  endtask

  initial begin
    logic [20:0] burst [5];
    int dither_last;

    burst[0] = 21'h100000;
    burst[1] = 21'h0FFFFF;
    burst[2] = 21'h000000;
    burst[3] = 21'h100000;
    burst[4] = 21'h0FFFFF;

    rst          = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample       = 21'h000000;

    repeat (3) step();
    check("ready_in_reset", sample_ready, 1'b0);
    rst = 1'b0;
    step();
    check("rst_pwm", pwm_out, 1'b0);
    check("rst_ufl", underflow, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ready", sample_ready, 1'b1);

    // zero, positive full scale, negative full scale
    push_one(21'h000000);
    push_one(21'h0FFFFF);
    push_one(21'h100000);
    check("fill3_count", fifo_count, 3'd3);
    enable = 1'b1;
    run_period("a_p0_mid", 128, 0);
    check("a_pop_count", fifo_count, 3'd2);
    run_period("a_p1_zero", 128, 0);
    run_period("a_p2_max", 255, 0);
    run_period("a_p3_min", 0, 1);
    run_period("a_p4_starved", 128, 1);

    enable = 1'b0;
    step();
    step();
    check("idle_pwm", pwm_out, 1'b0);
    check("idle_count", fifo_count, 3'd0);

    // back-to-back pushes while idle, fifth must be held off
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample = burst[i];
      step();
    end
    check("full_count", fifo_count, 3'd4);
    check("full_ready", sample_ready, 1'b0);
    sample = burst[4];
    step();
    step();
    check("held_count", fifo_count, 3'd4);
    check("held_ready", sample_ready, 1'b0);
    sample_valid = 1'b0;

    enable = 1'b1;
    run_period("b_p0_mid", 128, 0);
    run_period("b_p1_min", 0, 0);
    run_period("b_p2_max", 255, 0);
    run_period("b_p3_zero", 128, 0);
    run_period("b_p4_min", 0, 1);
    run_period("b_p5_starved", 128, 1);

    // reset in mid-period discards queued samples
    push_one(21'h0FFFFF);
    push_one(21'h0FFFFF);
    check("pre_rst_count", fifo_count, 3'd2);
    repeat (98) step();
    rst = 1'b1;
    step();
    check("ready_in_reset2", sample_ready, 1'b0);
    check("rst2_count", fifo_count, 3'd0);
    check("rst2_pwm", pwm_out, 1'b0);
    rst = 1'b0;
    #1;
    check("rst2_ready_back", sample_ready, 1'b1);
    step();
    run_period("c_p0_mid", 128, 1);

    // small constant sample: residue 0x800 of 0x2000 carries every 4th pop
    enable = 1'b0;
    step();
    for (int i = 0; i < 4; i++) push_one(21'h000800);
    check("dither_fill_count", fifo_count, 3'd4);
`ifdef AUDIO_PWM_SINK_DITHER_EN
    dither_last = 129;
`else
    dither_last = 128;
`endif
    enable = 1'b1;
    run_period("d_p0", 128, 0);
    run_period("d_p1", 128, 0);
    run_period("d_p2", 128, 0);
    run_period("d_p3", 128, 0);
    run_period("d_p4", dither_last, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_pwm_sink.md
AUDIO_PWM_SINK -- requirements
Module: audio_pwm_sink

Interface
REQ-001 SHALL have parameter CPU_CLOCK_FREQ, default 50_000_000, system clock frequency in Hz (documentation only, no functional effect).
REQ-002 SHALL have parameter PWM_BITS, default 10, PWM resolution; period = 2^PWM_BITS clk cycles.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries, power of two, >= 2.
REQ-004 SHALL have port clk, input, 1, clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port enable, input, 1, runs the PWM counter and FIFO pops.
REQ-007 SHALL have port sample, input, 21, signed two's-complement sample.
REQ-008 SHALL have port sample_valid, input, 1, sample present.
REQ-009 SHALL have port sample_ready, output, 1, FIFO can accept a sample.
REQ-010 SHALL have port pwm_out, output, 1, registered PWM drive.
REQ-011 SHALL have port underflow, output, 1, one-cycle pulse on FIFO starvation.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current occupancy.

Function
REQ-013 SHALL accept a sample on a clk edge where sample_valid & sample_ready are both high.
REQ-014 SHALL drive sample_ready = (fifo_count != FIFO_DEPTH) & !rst, evaluated from the registered count.
REQ-015 SHALL, when full, hold off further pushes; a pop in the same cycle does not enable a push in that cycle.
REQ-016 SHALL, while enable=1, run a period counter cnt 0..2^PWM_BITS-1 that wraps to 0.
REQ-017 SHALL, while enable=0, hold cnt at 0, drive pwm_out 0, perform no pops, and keep the FIFO accepting until full.
REQ-018 SHALL attempt a pop on cycles where cnt == 2^PWM_BITS-1 and enable=1; the new duty takes effect at cnt == 0.
REQ-019 SHALL convert a sample to duty as sample[20:21-PWM_BITS] with the MSB inverted (offset binary), zero-extended to PWM_BITS+1 bits.
REQ-020 SHALL, on a pop attempt with the FIFO empty, load duty = 2^(PWM_BITS-1) (midscale) and pulse underflow for exactly 1 cycle.
REQ-021 SHALL, when a push arrives in the same cycle as a pop attempt on an empty FIFO, register the underflow and store the pushed sample.
REQ-022 SHALL register pwm_out <= (cnt < duty), so duty d gives exactly d high cycles per period (0 = always low, 2^PWM_BITS = always high).

Reset
REQ-023 SHALL reset to: cnt=0, duty=2^(PWM_BITS-1), FIFO empty (fifo_count=0), pwm_out=0, underflow=0, dither accumulator=0.
REQ-024 SHALL, when reset is asserted mid-period, discard all FIFO contents; sample_ready returns to 1 on the first cycle after reset deasserts.

Configuration
REQ-025 SHALL, with AUDIO_PWM_SINK_DITHER_EN defined, add the discarded low 21-PWM_BITS bits to an accumulator of the same width on each successful pop; a carry out of the accumulator adds 1 to that period's duty (max 2^PWM_BITS).
REQ-026 SHALL, without AUDIO_PWM_SINK_DITHER_EN, truncate the low bits with no accumulator present.

Structure
REQ-027 SHALL place the sample width (21), the midscale function and the offset-binary conversion function in the shared audio package used by the NCO.
REQ-028 SHALL implement the sample FIFO as the sub-module sample_fifo (synchronous, count output, push/pop/full/empty).

Verification (PWM_BITS=8, FIFO_DEPTH=4)
REQ-029 SHALL check: reset held for 3 cycles, then released -> pwm_out=0, underflow=0, fifo_count=0, sample_ready=1.
REQ-030 SHALL check: push 21'h000000, enable=1 -> every following period has 128 high cycles out of 256.
REQ-031 SHALL check: push 21'h0FFFFF, then 21'h100000 -> periods with 255 high cycles, then 0 high cycles.
REQ-032 SHALL check: enable=0, push 5 samples back-to-back -> sample_ready falls after the 4th, the 5th is held, fifo_count=4.
REQ-033 SHALL check: FIFO drained, enable=1 -> underflow is high for exactly 1 cycle at cnt=255, and the next period has 128 high cycles.
REQ-034 SHALL check, with DITHER_EN defined: repeated 21'h000800 -> duty sequence 128,128,128,129 repeating; without DITHER_EN -> constant 128.
